mac_acc_signed: RTL



---
 rtl/mac_acc_signed.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mac_acc_signed.sv
// mac_acc_signed
//   Signed saturating accumulator that sits behind the N x M signed multiplier.
//   It sums exactly LEN products per dot-product operation and then presents
//   the result on an output valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a new operation (honoured only while idle)
//   in_valid   prod is valid this cycle
//   in_ready   product is accepted this cycle (decoded from state)
//   prod       signed (N+M)-bit product
//   out_valid  acc_out/sat hold the finished result (decoded from state)
//   out_ready  downstream accepts the result
//   acc_out    signed accumulator value (always the accumulator register)
//   sat        sticky flag: some add in this operation clamped
//   busy       high while accumulating or holding a result
module mac_acc_signed #(
  parameter int unsigned N     = 4,
  parameter int unsigned M     = 5,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned LEN   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N+M-1:0]     prod,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   acc_out,
  output logic               sat,
  output logic               busy
);

  localparam int unsigned PW = N + M;
  localparam int unsigned CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  if (ACC_W < PW) begin : g_bad_acc_w
    $error("mac_acc_signed: ACC_W must be >= N+M");
  end
  if (LEN < 1) begin : g_bad_len
    $error("mac_acc_signed: LEN must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q,   acc_d;
  logic [CW-1:0]     count_q, count_d;
  logic              sat_q,   sat_d;

  // One guard bit above the accumulator: the sum of two ACC_W-bit signed
  // values always fits, and disagreement of the top two bits flags overflow.
  logic [ACC_W:0]    sum;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    sat_d   = sat_q;
    sum     = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PW){prod[PW-1]}}, prod};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          if (sum[ACC_W] != sum[ACC_W-1]) begin
            sat_d = 1'b1;
            acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == S_ACCUM);
    out_valid = (state_q == S_HOLD);
    busy      = (state_q == S_ACCUM) || (state_q == S_HOLD);
    acc_out   = acc_q;
    sat       = sat_q;
  end

endmodule
